icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the fetch unit and the memory controller's IF port.
- On a hit, returns the instruction one cycle after the request.
- On a miss, issues one 32-bit fetch to the memory controller, fills the line and forwards the word to fetch.
- Absorbs pipeline flushes (clr) without abandoning an in-flight memory fetch.

Parameters:
IDX_WIDTH, 8, index bits; number of lines = 2^IDX_WIDTH; index = pc[IDX_WIDTH+1:2], tag = pc[31:IDX_WIDTH+2]

Ports:
clk  in  1  clock
rst  in  1  reset: rst, synchronous, active-high; clock clk
rdy  in  1  global enable; low = freeze every register, outputs hold
clr  in  1  pipeline flush (branch mispredict)
if_to_ic_valid  in  1  fetch request valid
if_to_ic_pc  in  32  fetch address, word aligned (pc[1:0] ignored)
ic_to_if_done  out  1  one-cycle pulse: instruction valid
ic_to_if_inst  out  32  instruction, valid only with done
ic_to_mc_enable  out  1  memory fetch request, level
ic_to_mc_pc  out  32  memory fetch address
mc_to_ic_done  in  1  one-cycle pulse from memory controller
mc_to_ic_result  in  32  fetched word, valid with mc_to_ic_done

Behaviour:
- Storage: data[2^IDX_WIDTH] x32, tag[2^IDX_WIDTH] x(30-IDX_WIDTH), valid bit vector.
- Reset:
  - valid vector cleared (all lines invalid); state IDLE; abort=0.
  - ic_to_if_done=0, ic_to_if_inst=0, ic_to_mc_enable=0, ic_to_mc_pc=0.
  - data and tag arrays are not reset.
- ic_to_if_done and ic_to_if_inst are registered. Default each active cycle: done<=0, inst<=0.
- ic_to_mc_enable = (state==MISS). ic_to_mc_pc = miss_pc register; it is 0 in IDLE.
- States IDLE and MISS.
  - IDLE, valid && !clr, hit (valid[idx] && tag match): done<=1 and inst<=data[idx] at the next edge. 1-cycle latency. Stay IDLE. Back-to-back hits are accepted every cycle.
  - IDLE, valid && !clr, miss: miss_pc<={pc[31:2],2'b00}; abort<=0; go MISS. No done pulse.
  - IDLE with clr=1: the request is ignored, with no lookup and no state change.
  - MISS: enable held high, miss_pc stable; if_to_ic_valid is ignored. The fetch unit holds its request until done; it is not re-sampled.
  - MISS, mc_to_ic_done=1:
    - Write data, tag and valid for miss_pc's index.
    - If abort==0 and clr==0: done<=1, inst<=mc_to_ic_result.
    - State<=IDLE, which drops enable at the same edge. Enable is therefore low during the controller's post-transaction idle cycle, so no duplicate fetch is launched.
  - MISS, clr=1 with no mc done: abort<=1.
    - Enable stays high; the in-flight controller fetch cannot be cancelled.
    - The fill still completes and the line is written, but no done pulse is sent.
- clr also forces the registered done/inst to 0 on that edge, so no stale instruction is delivered post-flush.
- The first request after an aborted miss is serviced only after returning to IDLE. Fetch must re-present it.
- A fill to an index overwrites any previous line (direct-mapped replacement).
- A hit and a fill are never concurrent (lookups happen only in IDLE).
- rdy=0 mid-MISS: state, abort and enable hold; the mc done pulse is not expected while rdy=0.
- rst mid-MISS: return to IDLE, invalidate all lines, drop enable at the next edge.

Test Plan:
- Cold miss:
  - Stimulus: after reset, valid=1, pc=0x00001000.
  - Required response: next cycle enable=1, mc_pc=0x1000. Model mc returns done + 0x00500093 five cycles later. One cycle later if_done=1, inst=0x00500093, and enable=0 in that same cycle.
- Hit after fill:
  - Stimulus: re-request pc=0x1000.
  - Required response: if_done=1, inst=0x00500093 on the following cycle, enable never asserted.
  - Then three consecutive hits produce three consecutive done pulses.
- Conflict eviction (IDX_WIDTH=8):
  - Stimulus: fill 0x1000, then request 0x1400 (same index 0, different tag).
  - Required response: 0x1400 misses and fills; a later request to 0x1000 misses again.
- Flush during miss:
  - Stimulus: miss on 0x2000, assert clr for one cycle before mc done.
  - Required response: enable stays 1 until mc done; no if_done pulse; enable drops after done. A later 0x2000 request hits with the filled word.
- Flush in IDLE and freeze:
  - clr=1 with valid=1 on a cached pc: no done pulse next cycle.
  - rdy=0 for 3 cycles during MISS: enable and mc_pc unchanged.
- Reset mid-miss:
  - Stimulus: assert rst while in MISS.
  - Required response: enable=0 and if_done=0 after the edge; a previously cached pc now misses.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller IF port; a flush during a miss lets the fill finish silently.
module icache_direct #(
    parameter int IDX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        if_to_ic_valid,
    input  logic [31:0] if_to_ic_pc,
    output logic        ic_to_if_done,
    output logic [31:0] ic_to_if_inst,
    output logic        ic_to_mc_enable,
    output logic [31:0] ic_to_mc_pc,
    input  logic        mc_to_ic_done,
    input  logic [31:0] mc_to_ic_result
);

    localparam int LINES = 1 << IDX_WIDTH;
    localparam int TAG_W = 30 - IDX_WIDTH;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    logic [31:0]      data_mem [LINES];
    logic [TAG_W-1:0] tag_mem  [LINES];

    state_t           state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic             abort_q, abort_d;
    logic [31:0]      miss_pc_q, miss_pc_d;
    logic             done_q, done_d;
    logic [31:0]      inst_q, inst_d;
    logic             fill_we;

    logic [IDX_WIDTH-1:0] req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [IDX_WIDTH-1:0] fill_idx;
    logic [TAG_W-1:0]     fill_tag;
    logic                 hit;
    logic                 unused_pc_bits;

    assign req_idx        = if_to_ic_pc[IDX_WIDTH+1:2];
    assign req_tag        = if_to_ic_pc[31:IDX_WIDTH+2];
    assign fill_idx       = miss_pc_q[IDX_WIDTH+1:2];
    assign fill_tag       = miss_pc_q[31:IDX_WIDTH+2];
    assign hit            = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_pc_bits = ^if_to_ic_pc[1:0];

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        abort_d   = abort_q;
        miss_pc_d = miss_pc_q;
        done_d    = 1'b0;
        inst_d    = '0;
        fill_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_to_ic_valid && !clr) begin
                    if (hit) begin
                        done_d = 1'b1;
                        inst_d = data_mem[req_idx];
                    end else begin
                        miss_pc_d = {if_to_ic_pc[31:2], 2'b00};
                        abort_d   = 1'b0;
                        state_d   = MISS;
                    end
                end
            end
            MISS: begin
                if (mc_to_ic_done) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    if (!abort_q && !clr) begin
                        done_d = 1'b1;
                        inst_d = mc_to_ic_result;
                    end
                    // Clearing miss_pc keeps ic_to_mc_pc at zero whenever idle.
                    miss_pc_d = '0;
                    state_d   = IDLE;
                end else if (clr) begin
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            abort_q   <= 1'b0;
            miss_pc_q <= '0;
            done_q    <= 1'b0;
            inst_q    <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            abort_q   <= abort_d;
            miss_pc_q <= miss_pc_d;
            done_q    <= done_d;
            inst_q    <= inst_d;
        end
    end

    // Line payload is left unreset; the valid vector alone gates hits.
    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            data_mem[fill_idx] <= mc_to_ic_result;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    assign ic_to_if_done   = done_q;
    assign ic_to_if_inst   = inst_q;
    assign ic_to_mc_enable = (state_q == MISS);
    assign ic_to_mc_pc     = miss_pc_q;

endmodule
